// File: rtl/karatsuba_combine_seq.sv
// karatsuba_combine_seq: recombines Karatsuba partial products into the full product with one shared adder
module karatsuba_combine_seq #(
  parameter int N_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_BITS-1:0]     z0,
  input  logic [N_BITS+1:0]     z1,
  input  logic [N_BITS-1:0]     z2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*N_BITS-1:0]   p,
  output logic                  err
);
  localparam int H = N_BITS / 2;
  typedef enum logic [2:0] {IDLE, SUB0, SUB2, ADD, DONE} state_t;
  state_t state, state_nxt;
  logic [N_BITS-1:0] z0_q, z2_q;
  logic [N_BITS+1:0] mid;
  logic [N_BITS+2:0] diff;
  logic [2*N_BITS:0] sum;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (in_valid ? SUB0 : IDLE) :
                state == SUB0 ? SUB2 :
                state == SUB2 ? ADD :
                state == ADD  ? DONE :
                out_ready     ? IDLE : DONE;
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
  end
  // The extra top bit of diff is the borrow; sum's top bit is the final carry-out
  always_comb begin
    diff = {1'b0, mid} - {3'b0, state == SUB0 ? z0_q : z2_q};
    sum  = {1'b0, z2_q, z0_q} + ({{(N_BITS-1){1'b0}}, mid} << H);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      z0_q <= '0;
      z2_q <= '0;
      mid  <= '0;
      p    <= '0;
      err  <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      z0_q <= z0;
      z2_q <= z2;
      mid  <= z1;
      err  <= 1'b0;
    end else if (state == SUB0 || state == SUB2) begin
      mid <= diff[N_BITS+1:0];
      err <= err | diff[N_BITS+2];
    end else if (state == ADD) begin
      p   <= sum[2*N_BITS-1:0];
      err <= err | sum[2*N_BITS];
    end
endmodule
